// File: rtl/unsigned_restoring_divider_if.sv
// Start/busy/done handshake bundle shared by the multi-cycle arithmetic units.
// The controller side is the master; the arithmetic unit is the slave.
interface unsigned_restoring_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/unsigned_restoring_divider.sv
// Multi-cycle unsigned restoring divider that retires one quotient bit per clock.
// A zero divisor short-circuits straight to DONE with an all-ones quotient.
module unsigned_restoring_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    unsigned_restoring_divider_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_div;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_dbz;
    logic               w_accept;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH+1:0]   w_trial;

    assign w_accept   = (r_state != RUN) && bus.start;
    assign w_remShift = {r_rem, r_quo[WIDTH-1]};
    // Extra top bit acts as the borrow: set means the trial subtraction went negative.
    assign w_trial    = {1'b0, w_remShift} - {2'b00, r_div};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_nextState = (bus.divisor == '0) ? DONE : RUN;
                end else begin
                    w_nextState = IDLE;
                end
            end
            RUN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_nextState = DONE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (r_state)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if (w_accept) begin
            r_div <= bus.divisor;
            if (bus.divisor == '0) begin
                r_quo <= '1;
                r_rem <= bus.dividend;
                r_dbz <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_quo <= bus.dividend;
                r_rem <= '0;
                r_dbz <= 1'b0;
                r_cnt <= CNT_W'(WIDTH);
            end
        end else if (r_state == RUN) begin
            // The partial remainder never reaches the divisor, so it always fits back in WIDTH bits.
            if (w_trial[WIDTH+1]) begin
                r_rem <= WIDTH'(w_remShift);
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end else begin
                r_rem <= WIDTH'(w_trial);
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign bus.quotient    = r_quo;
    assign bus.remainder   = r_rem;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_unsigned_restoring_divider.sv
// Scoreboard bench for the restoring divider: expected results are queued at launch
// and compared, along with completion timing, whenever done pulses.
module tb_unsigned_restoring_divider;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        int               doneEdge;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   edgeCount = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    unsigned_restoring_divider_if #(.WIDTH(WIDTH)) bus ();

    unsigned_restoring_divider #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called on the negedge before the accepting edge, so E0 is edgeCount+1.
    task automatic pushExpected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
            e.dbz = 1'b1;
            e.doneEdge = edgeCount + 1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.dbz = 1'b0;
            e.doneEdge = edgeCount + 1 + WIDTH;
        end
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        pushExpected(a, b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checkOutput("drain timeout", 64'(sb.size()), 0);
            sb.delete();
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", 64'(bus.quotient), 64'(e.q));
                checkOutput("remainder", 64'(bus.remainder), 64'(e.r));
                checkOutput("div_by_zero", 64'(bus.div_by_zero), 64'(e.dbz));
                checkOutput("done latency", 64'(edgeCount), 64'(e.doneEdge));
                if (!e.dbz) begin
                    checkOutput("identity", {32'b0, bus.quotient} * {32'b0, e.b} + {32'b0, bus.remainder},
                                {32'b0, e.a});
                    checkOutput("rem below div", 64'(bus.remainder < e.b), 1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #12;
        checkOutput("reset busy", 64'(bus.busy), 0);
        checkOutput("reset done", 64'(bus.done), 0);
        checkOutput("reset quotient", 64'(bus.quotient), 0);
        checkOutput("reset remainder", 64'(bus.remainder), 0);
        checkOutput("reset dbz", 64'(bus.div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] basic 100/7");
        applyStimulus(100, 7);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!bus.busy) break;
            n++;
            @(negedge clk);
        end
        checkOutput("busy cycles", 64'(n), WIDTH);
        checkOutput("done after last iteration", 64'(bus.done), 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("hold done", 64'(bus.done), 0);
            checkOutput("hold quotient", 64'(bus.quotient), 14);
            checkOutput("hold remainder", 64'(bus.remainder), 2);
        end

        $display("[TB] extremes");
        applyStimulus(32'hFFFF_FFFF, 1);
        waitDrain(100);
        applyStimulus(5, 9);
        waitDrain(100);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        waitDrain(100);

        $display("[TB] divide by zero");
        applyStimulus(32'h1234, 0);
        waitDrain(10);
        applyStimulus(9, 3);
        waitDrain(100);

        $display("[TB] reset mid-run");
        applyStimulus(100, 7);
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset busy", 64'(bus.busy), 0);
        checkOutput("async reset done", 64'(bus.done), 0);
        checkOutput("async reset quotient", 64'(bus.quotient), 0);
        checkOutput("async reset remainder", 64'(bus.remainder), 0);
        checkOutput("async reset dbz", 64'(bus.div_by_zero), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        applyStimulus(100, 7);
        waitDrain(100);

        $display("[TB] start held high with changing operands");
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 1000;
        bus.divisor = 7;
        pushExpected(1000, 7);
        for (int k = 1; k <= WIDTH; k++) begin
            @(negedge clk);
            bus.dividend = $urandom;
            bus.divisor = $urandom;
        end
        @(negedge clk);
        checkOutput("done in held-start run", 64'(bus.done), 1);
        bus.dividend = 77;
        bus.divisor = 5;
        pushExpected(77, 5);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("done drops on relaunch", 64'(bus.done), 0);
        checkOutput("busy on relaunch", 64'(bus.busy), 1);
        waitDrain(100);

        $display("[TB] random operands");
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 1;
            applyStimulus(a, b);
            waitDrain(100);
        end

        repeat (5) @(negedge clk);
        checkOutput("scoreboard empty", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/unsigned_restoring_divider.md
Name: unsigned_restoring_divider

Overview:
- Multi-cycle unsigned integer divider: the inverse of the shift-add unsigned multiplier datapath, built from the same register/ALU flavour.
- Produces quotient and remainder with a restoring shift-subtract algorithm, one quotient bit per clock.
- Uses a start/busy/done handshake so the same controller style drives multiply and divide in the arithmetic unit.

Parameters:
WIDTH, 32, operand/result width in bits (dividend, divisor, quotient, remainder)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous, active-high; clears all state and outputs
start  input  1  request to begin a division; sampled only when busy=0
dividend  input  WIDTH  unsigned dividend, captured on the accepting edge
divisor  input  WIDTH  unsigned divisor, captured on the accepting edge
busy  output  1  high while an operation is in progress (state RUN)
done  output  1  one-cycle pulse: results valid this cycle
quotient  output  WIDTH  unsigned quotient, held until next accepted start
remainder  output  WIDTH  unsigned remainder, held until next accepted start
div_by_zero  output  1  set with done when captured divisor was 0; held with results

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; busy=0, done=0, div_by_zero=0, quotient=0, remainder=0; internal divisor register and counter cleared. Operation in flight is abandoned, and no done pulse is produced for it.
- States: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE or DONE, start=1 at edge E0:
  - captures dividend into the quotient shift register, divisor into the divisor register, and clears the remainder register.
  - div_by_zero is cleared.
  - If divisor≠0: counter=WIDTH, next state RUN.
  - If divisor=0: quotient=all ones, remainder=dividend, div_by_zero=1, next state DONE. done is high in the cycle after E0.
- IDLE or DONE, start=0: DONE→IDLE, IDLE→IDLE. Outputs are held.
- RUN, each edge:
  - {R,Q} shifts left by 1; the MSB of Q enters the LSB of R. R is WIDTH+1 bits internally, so no overflow is lost.
  - trial = R_shifted − divisor (WIDTH+1 bits).
  - If trial ≥ 0: R=trial and Q[0]=1. Otherwise R is kept (restore) and Q[0]=0.
  - counter decrements. On the edge where counter goes 1→0, next state is DONE.
- Latency: the accepting edge is E0 and iterations occur on edges E1..EWIDTH. done is high in the cycle following edge EWIDTH, i.e. WIDTH+1 edges after start was sampled.
- quotient/remainder outputs:
  - In RUN they reflect the partial Q and R[WIDTH-1:0]; consumers must use them only when done=1 or afterwards.
  - After DONE they stay stable until the next accepted start.
- start while busy=1 is ignored. The operation in progress is unaffected and no request is queued.
- start asserted in the DONE cycle is accepted: a back-to-back operation begins and done drops next cycle.
- dividend/divisor changes after E0 have no effect on the current operation.
- Arithmetic identity on completion with divisor≠0: dividend = quotient×divisor + remainder, and remainder < divisor.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after 10 RUN cycles of 100/7 → busy, done, quotient, remainder and div_by_zero all 0 immediately; no done pulse follows; a new start afterwards works normally.
- Basic: dividend=100, divisor=7, start pulse at edge E0 → busy=1 for edges E1..E32; done=1 for exactly one cycle after E32; quotient=14, remainder=2, div_by_zero=0; values held for 20 idle cycles.
- Extremes:
  - 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 0xFFFFFFFF/0xFFFFFFFF → quotient=1, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0, start → done one cycle after E0; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1. A following 9/3 operation clears div_by_zero and yields quotient=3, remainder=0.
- Handshake:
  - start held high continuously with inputs changed every cycle during RUN → the first operation completes with the originally captured operands.
  - Start in the DONE cycle launches a second operation; done pulses exactly once per operation.
- Random: 1000 random operand pairs with nonzero divisor → each result satisfies dividend=q×d+r and r<d; done arrives exactly WIDTH+1 edges after acceptance.
